window_3x3: RTL

Forms a sliding 3x3 pixel window from three row-aligned pixel streams. The current row and two line-delayed copies come from two cascaded line-delay stages directly upstream. The block emits one packed 9-pixel window per accepted pixel whose window lies fully inside the frame. It feeds the 3x3 kernel stages (Sobel, box, median) downstream.

---
 rtl/window_3x3.sv | 93 +++++++++
 1 files changed

// File: rtl/window_3x3.sv
// Sliding 3x3 pixel window from three row-aligned streams; 1-cycle latency, no backpressure (ivalid-gated shift, holds when idle).
// Optional WINDOW_POS_EN macro adds registered window-centre coordinates ox/oy.
module window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ivalid,
    input  logic [WIDTH-1:0]         row0_in,
    input  logic [WIDTH-1:0]         row1_in,
    input  logic [WIDTH-1:0]         row2_in,
    output logic                     ovalid,
    output logic [9*WIDTH-1:0]       win_out,
`ifdef WINDOW_POS_EN
    output logic [$clog2(IMG_W)-1:0] ox,
    output logic [$clog2(IMG_H)-1:0] oy,
`endif
    output logic                     frame_end
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]    col;
    logic [YW-1:0]    row;
    // win[c][r]: c=0 oldest column, r=0 top row
    logic [WIDTH-1:0] win [3][3];
    logic             in_frame;
    logic             last_pix;

    assign in_frame = (col >= XW'(2)) && (row >= YW'(2));
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            ovalid    <= 1'b0;
            frame_end <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win[c][r] <= '0;
                end
            end
        end else if (ivalid) begin
            for (int r = 0; r < 3; r++) begin
                win[0][r] <= win[1][r];
                win[1][r] <= win[2][r];
            end
            win[2][0] <= row2_in;
            win[2][1] <= row1_in;
            win[2][2] <= row0_in;
            ovalid    <= in_frame;
            frame_end <= in_frame && last_pix;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end else begin
            ovalid    <= 1'b0;
            frame_end <= 1'b0;
        end
    end

    always_comb begin
        win_out = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_out[(r*3+c)*WIDTH +: WIDTH] = win[c][r];
            end
        end
    end

`ifdef WINDOW_POS_EN
    // Centre lags the incoming pixel by one column and one row.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ox <= '0;
            oy <= '0;
        end else if (ivalid && in_frame) begin
            ox <= col - XW'(1);
            oy <= row - YW'(1);
        end
    end
`endif

endmodule
